// File: rtl/sub_word_mem_ctrl.sv
// Sub-word load/store controller between the MEM stage and a word-wide synchronous RAM.
// Sub-word stores do a read-modify-write, and misaligned or reserved-size requests fail without touching memory.
module sub_word_mem_ctrl #(
   parameter int unsigned ADDR_W     = 32,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StDone} state_e;

   state_e            state_q, state_d;
   logic              we_q, uns_q, err_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, wbuf_q, rdata_q;

   logic        accept, bad_req, hi;
   logic [1:0]  lane;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_val, merged;

   assign accept  = req_valid && req_ready;
   assign bad_req = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   // For a 2-bit value, 3 - x equals ~x.
   assign lane = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
   assign hi   = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];

   always_comb begin
      sel_byte = mem_rdata[{lane, 3'b000} +: 8];
      sel_half = hi ? mem_rdata[31:16] : mem_rdata[15:0];
      unique case (size_q)
         2'b00:   load_val = {{24{~uns_q & sel_byte[7]}}, sel_byte};
         2'b01:   load_val = {{16{~uns_q & sel_half[15]}}, sel_half};
         default: load_val = mem_rdata;
      endcase
      merged = mem_rdata;
      if (size_q == 2'b00) begin
         merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
      end else if (hi) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (bad_req) begin
                  state_d = StDone;
               end else if (req_we && req_size == 2'b10) begin
                  state_d = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead:  state_d = StWait;
         StWait:  state_d = we_q ? StWrite : StDone;
         StWrite: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready  = !reset && state_q == StIdle;
      resp_valid = !reset && state_q == StDone;
      resp_rdata = rdata_q;
      resp_err   = err_q;
      mem_en     = !reset && (state_q == StRead || state_q == StWrite);
      mem_we     = !reset && state_q == StWrite;
      mem_addr   = reset ? '0 : addr_q[ADDR_W-1:2];
      mem_wdata  = '0;
      if (!reset && state_q == StWrite) begin
         mem_wdata = (size_q == 2'b10) ? wdata_q : wbuf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         wbuf_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= bad_req;
         end
         if (state_q == StWait) begin
            if (we_q) begin
               wbuf_q <= merged;
            end else begin
               rdata_q <= load_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_sub_word_mem_ctrl.sv
// Bench for sub_word_mem_ctrl: little- and big-endian instances run in lock-step against
// a byte-addressed reference memory, plus directed boundary, reset and back-to-back cases.
module tb_sub_word_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;

   logic        req_ready[2], resp_valid[2], resp_err[2], mem_en[2], mem_we[2];
   logic [31:0] resp_rdata[2], mem_wdata[2], mem_rdata[2];
   logic [29:0] mem_addr[2];

   logic [31:0] ram[2][16];
   logic [7:0]  mb[2][64];
   int          wr_cnt[2] = '{0, 0};
   int          rsp_cnt[2] = '{0, 0};
   int          ncmp = 0;
   int          nfail = 0;

   always #5 clk = ~clk;

   sub_word_mem_ctrl #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) u_le (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .mem_en(mem_en[0]),
      .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata[0])
   );

   sub_word_mem_ctrl #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) u_be (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .mem_en(mem_en[1]),
      .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata[1])
   );

   always @(posedge clk) begin
      for (int e = 0; e < 2; e++) begin
         if (mem_en[e]) begin
            if (mem_we[e]) begin
               ram[e][mem_addr[e][3:0]] <= mem_wdata[e];
               wr_cnt[e] <= wr_cnt[e] + 1;
            end else begin
               mem_rdata[e] <= ram[e][mem_addr[e][3:0]];
            end
         end
         if (resp_valid[e]) rsp_cnt[e] <= rsp_cnt[e] + 1;
      end
   end

   task automatic chk(input string tag, input int e, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s[%0s]: observed %h, expected %h", tag, e == 0 ? "le" : "be", obs, exp);
      end
   endtask

   // Reference memory is a plain byte array; endianness only decides how bytes compose.
   function automatic logic [31:0] ld_ref(input int e, input logic [1:0] size, input logic uns,
                                          input logic [31:0] addr);
      int          n;
      logic [31:0] v, m;
      logic [7:0]  b;
      n = 1 << size;
      v = '0;
      for (int i = 0; i < n; i++) begin
         b = mb[e][int'(addr[5:0]) + i];
         if (e == 0) v = v | (32'(b) << (8 * i));
         else        v = (v << 8) | 32'(b);
      end
      if (n < 4) begin
         m = (32'd1 << (8 * n)) - 32'd1;
         if (!uns && v[8*n-1]) v = v | ~m;
      end
      return v;
   endfunction

   task automatic st_ref(input int e, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
      int n;
      n = 1 << size;
      for (int i = 0; i < n; i++) begin
         if (e == 0) mb[e][int'(addr[5:0]) + i] = wdata[8*i +: 8];
         else        mb[e][int'(addr[5:0]) + i] = wdata[8*(n-1-i) +: 8];
      end
   endtask

   task automatic init_word(input int idx, input logic [31:0] w);
      for (int e = 0; e < 2; e++) ram[e][idx] = w;
      for (int k = 0; k < 4; k++) begin
         mb[0][4*idx + k] = w[8*k +: 8];
         mb[1][4*idx + k] = w[8*(3-k) +: 8];
      end
   endtask

   task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] obs0, output logic [31:0] obs1);
      logic        err;
      int          lat, wcyc, nen;
      logic [31:0] exp_rd[2], exp_w[2], w_data[2], w_addr[2];
      int          rv_cyc[2], w_cyc[2], en_cnt[2];
      err  = size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
      lat  = err ? 1 : (!we ? 3 : (size == 2'd2 ? 2 : 4));
      wcyc = (we && !err) ? lat - 1 : -1;
      nen  = err ? 0 : ((we && size != 2'd2) ? 2 : 1);
      for (int e = 0; e < 2; e++) begin
         exp_rd[e] = (!we && !err) ? ld_ref(e, size, uns, addr) : 32'd0;
         exp_w[e]  = '0;
         if (we && !err) begin
            st_ref(e, size, addr, wdata);
            exp_w[e] = ld_ref(e, 2'd2, 1'b1, {addr[31:2], 2'b00});
         end
         rv_cyc[e] = -1; w_cyc[e] = -1; en_cnt[e] = 0; w_data[e] = '0; w_addr[e] = '0;
      end
      @(negedge clk);
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      for (int e = 0; e < 2; e++) chk("ready_idle", e, 32'(req_ready[e]), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         for (int e = 0; e < 2; e++) begin
            if (k == 1) chk("ready_busy", e, 32'(req_ready[e]), 32'd0);
            if (resp_valid[e] && rv_cyc[e] < 0) rv_cyc[e] = k;
            if (mem_en[e]) en_cnt[e]++;
            if (mem_en[e] && mem_we[e]) begin
               w_cyc[e] = k; w_data[e] = mem_wdata[e]; w_addr[e] = 32'(mem_addr[e]);
            end
         end
      end
      for (int e = 0; e < 2; e++) begin
         chk("resp_cycle", e, 32'(rv_cyc[e]), 32'(lat));
         chk("resp_rdata", e, resp_rdata[e], exp_rd[e]);
         chk("resp_err", e, 32'(resp_err[e]), 32'(err));
         chk("mem_en_cycles", e, 32'(en_cnt[e]), 32'(nen));
         chk("write_cycle", e, 32'(w_cyc[e]), 32'(wcyc));
         if (we && !err) begin
            chk("write_data", e, w_data[e], exp_w[e]);
            chk("write_addr", e, w_addr[e], 32'(addr[31:2]));
         end
      end
      obs0 = resp_rdata[0];
      obs1 = resp_rdata[1];
   endtask

   task automatic chk_idle_outputs(input string tag, input logic rdy);
      for (int e = 0; e < 2; e++) begin
         chk({tag, "_ready"}, e, 32'(req_ready[e]), 32'(rdy));
         chk({tag, "_rvalid"}, e, 32'(resp_valid[e]), 32'd0);
         chk({tag, "_rdata"}, e, resp_rdata[e], 32'd0);
         chk({tag, "_err"}, e, 32'(resp_err[e]), 32'd0);
         chk({tag, "_mem"}, e, {mem_en[e], mem_we[e], mem_addr[e]}, 32'd0);
         chk({tag, "_wdata"}, e, mem_wdata[e], 32'd0);
      end
   endtask

   initial begin
      logic [31:0] o0, o1;
      int w0[2], r0[2];
      int last, nacc;
      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 16; i++) init_word(i, $urandom);
      init_word(4, 32'h80FF7F01);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("reset", 1'b0);
      reset = 1'b0;
      @(negedge clk);
      for (int e = 0; e < 2; e++) chk("ready_after_reset", e, 32'(req_ready[e]), 32'd1);

      do_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, o0, o1);
      chk("lb_13", 0, o0, 32'hFFFFFF80);
      chk("lb_13", 1, o1, 32'h00000001);
      do_op(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, o0, o1);
      chk("lbu_13", 0, o0, 32'h00000080);
      do_op(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, o0, o1);
      chk("lb_10", 0, o0, 32'h00000001);
      do_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, o0, o1);
      chk("lh_12", 0, o0, 32'hFFFF80FF);
      chk("lh_12", 1, o1, 32'h00007F01);
      do_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, o0, o1);
      chk("lhu_12", 0, o0, 32'h000080FF);
      do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, o0, o1);
      chk("lw_10", 0, o0, 32'h80FF7F01);
      chk("lw_10", 1, o1, 32'h80FF7F01);

      do_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AA, o0, o1);
      do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, o0, o1);
      chk("sb_11", 0, o0, 32'h80FFAA01);
      chk("sb_11", 1, o1, 32'h80AA7F01);
      init_word(4, 32'h80FF7F01);
      do_op(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, o0, o1);
      do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, o0, o1);
      chk("sh_12", 0, o0, 32'hBEEF7F01);
      chk("sh_12", 1, o1, 32'h80FFBEEF);
      do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, o0, o1);
      do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, o0, o1);
      chk("sw_10", 0, o0, 32'hCAFEF00D);

      do_op(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, o0, o1);
      do_op(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, o0, o1);
      do_op(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, o0, o1);
      do_op(1'b1, 2'd2, 1'b0, 32'h21, 32'hDEADBEEF, o0, o1);

      // Reset lands while the sb is in WAIT; the write must never happen.
      init_word(4, 32'h80FF7F01);
      @(negedge clk);
      req_we = 1'b1; req_size = 2'd0; req_addr = 32'h11; req_wdata = 32'h000000AA;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int e = 0; e < 2; e++) begin w0[e] = wr_cnt[e]; r0[e] = rsp_cnt[e]; end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_idle_outputs("mid_reset", 1'b0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      for (int e = 0; e < 2; e++) begin
         chk("dropped_write", e, 32'(wr_cnt[e] - w0[e]), 32'd0);
         chk("dropped_resp", e, 32'(rsp_cnt[e] - r0[e]), 32'd0);
      end
      do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, o0, o1);
      chk("lw_after_reset", 0, o0, 32'h80FF7F01);
      chk("lw_after_reset", 1, o1, 32'h80FF7F01);

      repeat (40) begin
         do_op(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(63)), $urandom,
               o0, o1);
      end

      // Back-to-back word loads with req_valid held high.
      @(negedge clk);
      req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h14;
      req_valid = 1'b1;
      last = -1; nacc = 0;
      for (int k = 0; k < 17; k++) begin
         if (req_ready[0]) begin
            if (last >= 0) chk("b2b_gap", 0, 32'(k - last), 32'd4);
            last = k;
            nacc++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 0, 32'(nacc), 32'd5);
      repeat (6) @(negedge clk);
      for (int e = 0; e < 2; e++)
         chk("b2b_rdata", e, resp_rdata[e], ld_ref(e, 2'd2, 1'b0, 32'h14));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/sub_word_mem_ctrl.md
# sub_word_mem_ctrl

Multi-cycle data-memory access controller that sits between the CPU's MEM stage and a word-wide synchronous data RAM. It executes byte, halfword and word loads and stores, with sign or zero extension on loads and read-modify-write for sub-word stores. It detects misaligned accesses without touching memory, and selects little- or big-endian byte-lane mapping by parameter. It generalises the old byte-only load extractor to all access sizes, both directions and both endiannesses.

## Interface
- ADDR_W, 32, byte-address width; the memory word address is ADDR_W-2 bits.
- BIG_ENDIAN, 0, 0 selects lane = addr[1:0]; 1 selects lane = 3 - addr[1:0] (halfword: LE upper half when addr[1]=1, BE upper half when addr[1]=0).

- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  access request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (error).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores and words.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; byte uses [7:0], half uses [15:0].
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned or reserved size.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable (only with mem_en).
- mem_addr  out  ADDR_W-2  word address = latched addr[ADDR_W-1:2].
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  RAM read data, valid the cycle after a read with mem_en=1, mem_we=0.

## Operation
- On accept, latch we, size, unsigned, addr and wdata; the request inputs are then ignored until IDLE.
- Error check at accept: half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> DONE with resp_err=1. No memory access is made.
- States:
  - IDLE: next state READ for loads and byte/half stores, WRITE for word stores, DONE for errors.
  - READ: mem_en=1, mem_we=0 -> WAIT.
  - WAIT: mem_rdata valid this cycle.
    - Load: select lane(s), extend, register into resp_rdata -> DONE.
    - Sub-word store: register merged word (mem_rdata with target lane(s) replaced by wdata) into write buffer -> WRITE.
  - WRITE: mem_en=1, mem_we=1, mem_wdata = write buffer (or latched wdata for word stores) -> DONE.
  - DONE: resp_valid=1 -> IDLE.
- Byte lane n occupies bits [8n+7:8n].
- Sign extension replicates bit 7 (byte) or bit 15 (half) into the upper bits.
- Memory outputs are combinational from state and latched registers, and are forced to 0 while reset is high.

## Timing
- Reset values: state IDLE, req_ready 1 after reset deasserts (0 while reset high), resp_valid 0, resp_rdata 0, resp_err 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Latency from accept cycle 0 to resp_valid:
  - Load: READ 1, WAIT 2, DONE 3.
  - Word store: WRITE 1, DONE 2.
  - Sub-word store: READ 1, WAIT 2, WRITE 3, DONE 4.
  - Error: DONE 1.
- Exactly one write cycle per store; none for loads or errors.
- req_ready is 0 from cycle 1 through DONE. Next accept is possible in the cycle after DONE, so there is no same-cycle accept in DONE.
- resp_rdata and resp_err hold their values until the next DONE. The next accept clears them to 0 on the following edge.
- Reset mid-operation: state returns to IDLE at the edge. An in-flight store whose WRITE cycle has not occurred is dropped, and no resp_valid is produced.

## Test plan
- LE (BIG_ENDIAN=0), RAM[0x10]=0x80FF7F01:
  - lb 0x13 -> resp_rdata 0xFFFFFF80.
  - lbu 0x13 -> 0x00000080.
  - lb 0x10 -> 0x00000001.
  - All three: resp_valid in cycle 3, resp_err 0.
- Same RAM: lh 0x12 -> 0xFFFF80FF; lhu 0x12 -> 0x000080FF; lw 0x10 -> 0x80FF7F01. Repeat with BIG_ENDIAN=1: lb 0x13 -> 0x00000001, lh 0x12 -> 0x00007F01.
- sb 0x11 with wdata 0x123456AA on RAM[0x10]=0x80FF7F01 -> read cycle 1, write cycle 3 with mem_wdata 0x80FFAA01, resp_valid cycle 4. sh 0x12 wdata 0xBEEF -> 0xBEEF7F01. sw 0x10 wdata 0xCAFEF00D -> write cycle 1, resp cycle 2.
- lh 0x11, lw 0x12, size 11 -> resp_valid cycle 1, resp_err 1, resp_rdata 0, mem_en never asserted.
- Reset asserted during WAIT of an sb -> no write cycle, no resp_valid, all outputs at reset values; a following lw returns the unmodified word.
- req_valid held high continuously with back-to-back lw requests -> accepts separated by 4 cycles, req_ready low in between.
